// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if: CPU memory-load port driven by the serial boot loader
//   uart_addr  32  write byte address
//   uart_data  32  write data
//   uart_we     1  one-cycle write strobe
//   uart_done   1  image complete, hands memory port B back to the pipeline
interface uart_boot_loader_if;
   logic [31:0] uart_addr;
   logic [31:0] uart_data;
   logic        uart_we;
   logic        uart_done;
   modport master (output uart_addr, uart_data, uart_we, uart_done);
   modport slave  (input  uart_addr, uart_data, uart_we, uart_done);
endinterface

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: 8N1 UART receiver that loads a little-endian word image into memory
//   clk        system clock
//   rst        asynchronous active-low reset
//   rx         UART serial input, idle high
//   skip       forces completion while no header byte has been received
//   frame_err  sticky: bad stop bit or header word count above MAX_WORDS
//   mem        memory-load port (address, data, write strobe, done)
module uart_boot_loader #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned MAX_WORDS    = 16384
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx,
   input  logic               skip,
   output logic               frame_err,
   uart_boot_loader_if.master mem
);
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [1:0] {L_HDR, L_WORDS, L_DONE} ld_state_t;
   logic            rx_s1, rx_s2, rx_q;
   rx_state_t       rstate, rnext;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic            half, full, byte_v, stop_err, cnt_clr;
   ld_state_t       lstate, lnext;
   logic [1:0]      bcnt;
   logic [23:0]     acc;
   logic [31:0]     n_words, idx, word, addr, data;
   logic            we, ferr, last_byte, hdr_big;
   always_comb begin
      half     = cnt == CW'(CLKS_PER_BIT / 2 - 1);
      full     = cnt == CW'(CLKS_PER_BIT - 1);
      rnext    = rstate;
      byte_v   = 1'b0;
      stop_err = 1'b0;
      case (rstate)
         R_IDLE:  rnext = (rx_q && !rx_s2) ? R_START : R_IDLE;
         R_START: rnext = half ? (rx_s2 ? R_IDLE : R_DATA) : R_START;
         R_DATA:  rnext = (full && bit_idx == 3'd7) ? R_STOP : R_DATA;
         default: begin
            rnext    = full ? R_IDLE : R_STOP;
            byte_v   = full && rx_s2;
            stop_err = full && !rx_s2;
         end
      endcase
      // the bit timer restarts on every state change and on every data-bit sample
      cnt_clr = (rnext != rstate) || (rstate == R_DATA && full);
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) rstate <= R_IDLE;
      else      rstate <= rnext;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_q    <= 1'b1;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
         rx_q  <= rx_s2;
         cnt   <= (rstate == R_IDLE || cnt_clr) ? '0 : cnt + CW'(1);
         if (rstate == R_IDLE) bit_idx <= '0;
         else if (rstate == R_DATA && full) begin
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
      end
   always_comb begin
      word      = {shreg, acc};
      last_byte = byte_v && bcnt == 2'd3;
      hdr_big   = word > 32'(MAX_WORDS);
      lnext     = lstate;
      case (lstate)
         L_HDR:
            if (last_byte) lnext = (word == '0) ? L_DONE : L_WORDS;
            else if (!byte_v && bcnt == 2'd0 && skip) lnext = L_DONE;
         // done waits for the final strobe so the last write completes under loader ownership
         L_WORDS: lnext = (we && idx == n_words) ? L_DONE : L_WORDS;
         default: lnext = L_DONE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) lstate <= L_HDR;
      else      lstate <= lnext;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         bcnt    <= '0;
         acc     <= '0;
         n_words <= '0;
         idx     <= '0;
         addr    <= BASE_ADDR;
         data    <= '0;
         we      <= 1'b0;
         ferr    <= 1'b0;
      end else begin
         we <= lstate == L_WORDS && last_byte;
         if (stop_err || (lstate == L_HDR && last_byte && hdr_big)) ferr <= 1'b1;
         if (byte_v && lstate != L_DONE) begin
            bcnt <= bcnt + 2'd1;
            acc  <= {shreg, acc[23:8]};
         end
         if (lstate == L_HDR && last_byte) n_words <= hdr_big ? 32'(MAX_WORDS) : word;
         if (lstate == L_WORDS && last_byte) begin
            addr <= BASE_ADDR + (idx << 2);
            data <= word;
            idx  <= idx + 32'd1;
         end
      end
   assign mem.uart_addr = addr;
   assign mem.uart_data = data;
   assign mem.uart_we   = we;
   assign mem.uart_done = lstate == L_DONE;
   assign frame_err     = ferr;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed and randomized image loads checked against a byte-stream model
module tb_uart_boot_loader;
   localparam int          CPB  = 16;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int          MAXW = 4;
   logic clk = 1'b0, rst = 1'b0, rx = 1'b1, skip = 1'b0;
   logic frame_err;
   int   cyc = 0, checks = 0, errors = 0;
   logic [31:0] oa[$], od[$];
   int   oc[$], starts[$];
   int   done_cyc = -1, we_in_done = 0;
   uart_boot_loader_if mem();
   uart_boot_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
      .clk(clk), .rst(rst), .rx(rx), .skip(skip), .frame_err(frame_err), .mem(mem));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (rst) begin
         if (mem.uart_we) begin
            oa.push_back(mem.uart_addr);
            od.push_back(mem.uart_data);
            oc.push_back(cyc);
            if (mem.uart_done) we_in_done++;
         end
         if (mem.uart_done && done_cyc < 0) done_cyc = cyc;
      end
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, got, exp);
      end
   endtask
   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rx = 1'b0;
      starts.push_back(cyc);
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (4) @(negedge clk);
   endtask
   task automatic do_reset(input string tag);
      @(negedge clk);
      rst  = 1'b0;
      rx   = 1'b1;
      skip = 1'b0;
      repeat (3) @(negedge clk);
      chk({tag, "_rst_addr"}, mem.uart_addr, BASE);
      chk({tag, "_rst_data"}, mem.uart_data, 32'h0);
      chk({tag, "_rst_we"}, {31'h0, mem.uart_we}, 32'h0);
      chk({tag, "_rst_done"}, {31'h0, mem.uart_done}, 32'h0);
      chk({tag, "_rst_ferr"}, {31'h0, frame_err}, 32'h0);
      oa.delete(); od.delete(); oc.delete(); starts.delete();
      done_cyc   = -1;
      we_in_done = 0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
   endtask
   // bad: index of a byte sent with a low stop bit (-1 none); skip_after: raise skip after that many bytes
   task automatic run_image(input string tag, input logic [7:0] q[$], input int bad, input int skip_after);
      logic [7:0]  g[$];
      logic [31:0] ea[$], ed[$], n;
      logic        ef, full;
      int          hdr_start;
      ef = bad >= 0;
      for (int i = 0; i < q.size(); i++) if (i != bad) g.push_back(q[i]);
      n = {g[3], g[2], g[1], g[0]};
      if (n > MAXW) begin
         n  = MAXW;
         ef = 1'b1;
      end
      for (int i = 0; i < int'(n); i++)
         if (4 * i + 7 < g.size()) begin
            ea.push_back(BASE + 32'(4 * i));
            ed.push_back({g[4*i+7], g[4*i+6], g[4*i+5], g[4*i+4]});
         end
      full = g.size() >= 4 + 4 * int'(n);
      for (int i = 0; i < q.size(); i++) begin
         if (i == skip_after) skip = 1'b1;
         send_byte(q[i], i != bad);
      end
      hdr_start = starts[(bad >= 0 && bad < 4) ? 4 : 3];
      repeat (40) @(negedge clk);
      chk({tag, "_count"}, oa.size(), ea.size());
      for (int i = 0; i < ea.size(); i++) begin
         chk($sformatf("%s_addr%0d", tag, i), i < oa.size() ? oa[i] : 32'hx, ea[i]);
         chk($sformatf("%s_data%0d", tag, i), i < od.size() ? od[i] : 32'hx, ed[i]);
      end
      chk({tag, "_done"}, {31'h0, mem.uart_done}, {31'h0, full});
      if (full && n != 0)
         chk({tag, "_done_lat"}, done_cyc, (oc.size() > 0) ? oc[oc.size()-1] + 1 : -2);
      if (full && n == 0)
         chk({tag, "_done_hdr_lat"}, {31'h0, (done_cyc - hdr_start >= 154) && (done_cyc - hdr_start <= 158)}, 32'h1);
      chk({tag, "_ferr"}, {31'h0, frame_err}, {31'h0, ef});
      chk({tag, "_we_in_done"}, we_in_done, 0);
      skip = 1'b0;
   endtask
   function automatic logic [7:0] rb();
      return 8'($urandom_range(0, 255));
   endfunction
   initial begin
      logic [7:0] q[$];
      int nw;
      do_reset("t0");
      run_image("spec", '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                          8'h67, 8'h45, 8'h23, 8'h01}, -1, -1);
      for (int r = 0; r < 2; r++) begin
         do_reset("rnd");
         nw = $urandom_range(1, 3);
         q  = '{8'(nw), 8'h00, 8'h00, 8'h00};
         for (int i = 0; i < 4 * nw; i++) q.push_back(rb());
         run_image($sformatf("rnd%0d", r), q, -1, -1);
      end
      do_reset("zero");
      run_image("zero", '{8'h00, 8'h00, 8'h00, 8'h00}, -1, -1);
      do_reset("skip");
      skip = 1'b1;
      repeat (3) @(negedge clk);
      chk("skip_done", {31'h0, mem.uart_done}, 32'h1);
      for (int i = 0; i < 8; i++) send_byte(i < 4 ? (i == 0 ? 8'h01 : 8'h00) : rb(), 1'b1);
      repeat (20) @(negedge clk);
      chk("skip_nowrite", oa.size(), 0);
      skip = 1'b0;
      do_reset("skiplate");
      run_image("skiplate", '{8'h01, 8'h00, 8'h00, 8'h00, rb(), rb(), rb(), rb()}, -1, 1);
      do_reset("badstop");
      run_image("badstop", '{8'h01, 8'h00, 8'h00, 8'h00, rb(), 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 4, -1);
      do_reset("glitch");
      @(negedge clk);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_ferr", {31'h0, frame_err}, 32'h0);
      chk("glitch_done", {31'h0, mem.uart_done}, 32'h0);
      run_image("glitch", '{8'h01, 8'h00, 8'h00, 8'h00, rb(), rb(), rb(), rb()}, -1, -1);
      do_reset("midrst");
      for (int i = 0; i < 6; i++) send_byte(i == 0 ? 8'h01 : (i < 4 ? 8'h00 : rb()), 1'b1);
      do_reset("midrst2");
      run_image("midrst", '{8'h01, 8'h00, 8'h00, 8'h00, rb(), rb(), rb(), rb()}, -1, -1);
      do_reset("clamp");
      q = '{8'h06, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 24; i++) q.push_back(rb());
      run_image("clamp", q, -1, -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Serial boot loader that drives the CPU memory-load port (`uart_addr`, `uart_data`, `uart_we`, `uart_done`) from the board UART RX pin. It receives an 8N1 byte stream and assembles a little-endian word-count header and little-endian 32-bit words. Each word is issued as one write strobe to consecutive data-memory addresses. Once the image is complete it raises `uart_done`, which hands the memory port B mux back to the pipeline's MEM stage.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 8.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first loaded word.
- `MAX_WORDS`, 16384: largest accepted word count.

Ports:
- `clk`  input  1  system clock. One clock; reset is asynchronous and active-low.
- `rst`  input  1  asynchronous active-low reset.
- `rx`  input  1  UART serial input, asynchronous, idle high.
- `skip`  input  1  level input. While the loader is in HDR with no header byte received, `skip`=1 forces DONE.
- `uart_addr`  output  32  write address.
- `uart_data`  output  32  write data.
- `uart_we`  output  1  one-cycle write strobe.
- `uart_done`  output  1  image complete. Sticky until reset.
- `frame_err`  output  1  sticky. Set on stop-bit error or on header > `MAX_WORDS`.

## Operation
- `rx` passes through a 2-FF synchronizer. All sampling uses the synchronized value.
- RX FSM states and transitions:
  - IDLE: a synchronized high→low edge goes to START and clears the bit counter.
  - START: after `CLKS_PER_BIT/2` cycles, re-sample. If low, go to DATA. If high (glitch), go to IDLE.
  - DATA: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first.
  - STOP: sample once after `CLKS_PER_BIT` cycles. High → byte valid for 1 cycle. Low → byte discarded and `frame_err`=1. Either way, return to IDLE.
- Loader FSM states:
  - HDR: collects 4 valid bytes into N = {b3,b2,b1,b0}.
    - N=0 → DONE.
    - N>`MAX_WORDS` → N clamped to `MAX_WORDS` and `frame_err`=1.
    - Otherwise → WORDS with word index i=0.
  - WORDS: collects 4 bytes per word (first byte = bits [7:0]).
    - On the 4th byte: `uart_data`={b3,b2,b1,b0}, `uart_addr`=`BASE_ADDR`+4·i, `uart_we`=1, i increments.
    - When i reaches N → DONE.
  - DONE: `uart_done`=1. Further bytes are received but ignored, with no strobes. Exit only by reset.
- `skip` is sampled only in HDR while the header byte count is 0. Once any header byte has arrived, `skip` is ignored.
- Byte-within-word counter: 2 bits, wraps 3→0. Word index and address: 32-bit, modulo 2^32 (no saturation; only `MAX_WORDS` bounds it).
- Reset mid-operation: all state returns to reset values immediately, and any partially assembled word or header is lost.

## Timing
- Reset values: `uart_addr`=`BASE_ADDR`, `uart_data`=0, `uart_we`=0, `uart_done`=0, `frame_err`=0. RX FSM in IDLE, loader in HDR.
- Byte latency: the byte-valid pulse occurs 2 (sync) + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` cycles after the start edge reaches `rx`, ±1.
- `uart_we` asserts the cycle after the 4th byte-valid pulse of a word. `uart_addr`/`uart_data` are valid in that cycle and held until the next strobe.
- `uart_done` rises the cycle after the last `uart_we`, never in the same cycle, so the final write completes under loader ownership.
- Header completion with N=0: `uart_done` rises the cycle after the 4th header byte.
- `skip` path: `uart_done` rises the cycle after `skip` is first sampled high in HDR.
- `uart_we` is never asserted while `uart_done`=1.
- A byte-valid pulse and `skip` arriving in the same cycle: the byte wins, `skip` is ignored.

## Test plan
(Simulate with `CLKS_PER_BIT`=16, `BASE_ADDR`=32'h0000_1000.)
- Send 02 00 00 00, 13 00 00 00, 67 45 23 01 → two `uart_we` pulses: (32'h1000, 32'h0000_0013) then (32'h1004, 32'h0123_4567). `uart_done`=1 exactly one cycle after the second pulse. `frame_err`=0.
- Send header 00 00 00 00 → no `uart_we`. `uart_done`=1 the cycle after the 4th byte-valid pulse.
- Hold `skip`=1 after reset → `uart_done`=1 within 3 cycles. Subsequent bytes produce no strobes.
- Send header 01 00 00 00, then one byte with stop bit 0, then AA BB CC DD → `frame_err`=1. The bad byte is dropped and exactly one strobe is issued: (32'h1000, 32'hDDCC_BBAA).
- Apply a 4-cycle low glitch on idle `rx` → no byte-valid pulse and no `frame_err`. A following valid header still loads correctly.
- Assert `rst` low after 2 data bytes of word 0, then release and send a full 1-word image → all outputs at reset values during reset. After release, exactly one strobe at 32'h1000 with the new data.
